// File: rtl/chip8_boot_streamer_if.sv
// Boot-data host bus and program RAM upload port of chip8_boot_streamer.
// master = ZPUFlex host side, slave = streamer side.
interface chip8_boot_streamer_if;

  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic        host_bootdata_reset;
  logic [15:0] host_bootdata_size;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        loading;
  logic        core_rst_n;

  modport master (
    output host_bootdata,
    output host_bootdata_req,
    output host_bootdata_reset,
    output host_bootdata_size,
    input  host_bootdata_ack,
    input  ram_addr,
    input  ram_data,
    input  ram_we,
    input  loading,
    input  core_rst_n
  );

  modport slave (
    input  host_bootdata,
    input  host_bootdata_req,
    input  host_bootdata_reset,
    input  host_bootdata_size,
    output host_bootdata_ack,
    output ram_addr,
    output ram_data,
    output ram_we,
    output loading,
    output core_rst_n
  );

endinterface

// File: rtl/chip8_boot_streamer.sv
// Unpacks big-endian 32-bit boot words into Chip-8 program RAM byte writes.
// Define CHIP8_BOOT_ZERO_FILL_EN to zero the RAM above the loaded program.
module chip8_boot_streamer #(
  parameter logic [11:0] BASE_ADDR = 12'h200,
  parameter int unsigned RST_HOLD  = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  chip8_boot_streamer_if.slave bus
);

  localparam logic [12:0] ROOM =
    13'h1000 - {1'b0, BASE_ADDR};
  localparam logic [15:0] HOLD_LAST =
    16'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_END,
`ifdef CHIP8_BOOT_ZERO_FILL_EN
    S_FILL,
`endif
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state;
  logic [31:0] r_word;
  logic [31:0] w_word;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx;
  logic [12:0] r_cnt;
  logic [12:0] w_cnt;
  logic [12:0] r_limit;
  logic [12:0] w_limit;
  logic [15:0] r_size;
  logic [15:0] w_size;
  logic [16:0] r_taken;
  logic [16:0] w_taken;
  logic [11:0] r_addr;
  logic [11:0] w_addr;
  logic [15:0] r_hold;
  logic [15:0] w_hold;

  logic        r_ack;
  logic        w_ack;
  logic        r_ram_we;
  logic        w_ram_we;
  logic [11:0] r_ram_addr;
  logic [11:0] w_ram_addr;
  logic [7:0]  r_ram_data;
  logic [7:0]  w_ram_data;
  logic        r_loading;
  logic        w_loading;
  logic        r_core_rst_n;
  logic        w_core_rst_n;

  logic        w_big;
  logic [12:0] w_lim_in;
  logic        w_word_full;

  // Sizes beyond the RAM above BASE_ADDR are clipped to what fits.
  assign w_big =
    (|bus.host_bootdata_size[15:13]) ||
    (bus.host_bootdata_size[12:0] > ROOM);
  assign w_lim_in = w_big ?
    ROOM : bus.host_bootdata_size[12:0];

  assign w_word_full =
    r_taken >= {1'b0, r_size};

`ifdef CHIP8_BOOT_ZERO_FILL_EN
  logic [12:0] w_fill_pos;
  assign w_fill_pos =
    {1'b0, BASE_ADDR} + r_cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_limit      <= '0;
      r_size       <= '0;
      r_taken      <= '0;
      r_addr       <= BASE_ADDR;
      r_hold       <= '0;
      r_ack        <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= BASE_ADDR;
      r_ram_data   <= '0;
      r_loading    <= 1'b0;
      r_core_rst_n <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_word       <= w_word;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_limit      <= w_limit;
      r_size       <= w_size;
      r_taken      <= w_taken;
      r_addr       <= w_addr;
      r_hold       <= w_hold;
      r_ack        <= w_ack;
      r_ram_we     <= w_ram_we;
      r_ram_addr   <= w_ram_addr;
      r_ram_data   <= w_ram_data;
      r_loading    <= w_loading;
      r_core_rst_n <= w_core_rst_n;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_word       = r_word;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_limit      = r_limit;
    w_size       = r_size;
    w_taken      = r_taken;
    w_addr       = r_addr;
    w_hold       = r_hold;
    w_ack        = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_ram_addr;
    w_ram_data   = r_ram_data;
    w_loading    = r_loading;
    w_core_rst_n = r_core_rst_n;

    // A reset pulse restarts the load from any state and beats req.
    if (bus.host_bootdata_reset) begin
      w_limit      = w_lim_in;
      w_size       = bus.host_bootdata_size;
      w_cnt        = '0;
      w_taken      = '0;
      w_addr       = BASE_ADDR;
      w_hold       = '0;
      w_loading    = 1'b1;
      w_core_rst_n = 1'b0;
      if (w_lim_in == 13'd0) begin
`ifdef CHIP8_BOOT_ZERO_FILL_EN
        w_state = S_FILL;
`else
        w_state = S_DONE;
`endif
      end else begin
        w_state = S_FETCH;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end

        S_FETCH: begin
          if (bus.host_bootdata_req) begin
            w_word  = bus.host_bootdata;
            w_ack   = 1'b1;
            w_idx   = 2'd0;
            w_taken = r_taken + 17'd4;
            w_state = S_WRITE;
          end
        end

        S_WRITE: begin
          w_word = {r_word[23:0], 8'h00};
          w_idx  = r_idx + 2'd1;
          if (r_cnt < r_limit) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_addr;
            w_ram_data = r_word[31:24];
            w_addr     = r_addr + 12'd1;
            w_cnt      = r_cnt + 13'd1;
          end
          if (r_idx == 2'd3) begin
            if ((w_cnt >= r_limit) &&
                w_word_full) begin
              w_state = S_END;
            end else begin
              w_state = S_FETCH;
            end
          end
        end

        S_END: begin
`ifdef CHIP8_BOOT_ZERO_FILL_EN
          w_state   = S_FILL;
`else
          w_state   = S_DONE;
          w_loading = 1'b0;
          w_hold    = '0;
`endif
        end

`ifdef CHIP8_BOOT_ZERO_FILL_EN
        S_FILL: begin
          if (!w_fill_pos[12]) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_addr;
            w_ram_data = 8'h00;
            w_addr     = r_addr + 12'd1;
            w_cnt      = r_cnt + 13'd1;
          end else begin
            w_state   = S_DONE;
            w_loading = 1'b0;
            w_hold    = '0;
          end
        end
`endif

        S_DONE: begin
          w_loading = 1'b0;
          if (r_hold == HOLD_LAST) begin
            w_core_rst_n = 1'b1;
            w_state      = S_IDLE;
          end else begin
            w_hold = r_hold + 16'd1;
          end
        end

        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  assign bus.host_bootdata_ack = r_ack;
  assign bus.ram_we            = r_ram_we;
  assign bus.ram_addr          = r_ram_addr;
  assign bus.ram_data          = r_ram_data;
  assign bus.loading           = r_loading;
  assign bus.core_rst_n        = r_core_rst_n;

endmodule
